// File: rtl/nes_ctrl_pkg.sv
// Shared types and constants for the NES controller port.
package nes_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_CLK_HI = 3'd2,
    ST_CLK_LO = 3'd3,
    ST_COMMIT = 3'd4
  } poll_state_e;

  // Bit positions in the button vectors, in pad shift order.
  localparam logic [2:0] BTN_A      = 3'd0;
  localparam logic [2:0] BTN_B      = 3'd1;
  localparam logic [2:0] BTN_SELECT = 3'd2;
  localparam logic [2:0] BTN_START  = 3'd3;
  localparam logic [2:0] BTN_UP     = 3'd4;
  localparam logic [2:0] BTN_DOWN   = 3'd5;
  localparam logic [2:0] BTN_LEFT   = 3'd6;
  localparam logic [2:0] BTN_RIGHT  = 3'd7;

  // Undriven upper data bits read back as this value on the CPU bus.
  localparam logic [7:0] OPEN_BUS = 8'h40;

endpackage

// File: rtl/nes_controller_port_if.sv
// CPU-side bus for the $4016/$4017 controller registers.
interface nes_controller_port_if;
  logic       cs_n;
  logic       addr;
  logic       rd;
  logic       wr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;

  modport master (output cs_n, addr, rd, wr, wr_data, input rd_data);
  modport slave  (input cs_n, addr, rd, wr, wr_data, output rd_data);
endinterface

// File: rtl/nes_pad_poller.sv
// Free-running serial poller for both pads: latch, clock out 8 bits, commit.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | wait POLL_CYCLES between polls
//   ST_LATCH  | pad_latch high 2*HALF_BIT_CYCLES; bit 0 sampled on last cycle
//   ST_CLK_HI | pad_clk high HALF_BIT_CYCLES
//   ST_CLK_LO | pad_clk low HALF_BIT_CYCLES; next bit sampled on last cycle
//   ST_COMMIT | one cycle, commit pulse; captured vectors are complete
module nes_pad_poller
  import nes_ctrl_pkg::*;
#(
  parameter int POLL_CYCLES     = 100000,
  parameter int HALF_BIT_CYCLES = 300
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pad_data1_s,
  input  logic       pad_data2_s,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons1,
  output logic [7:0] buttons2,
  output logic       commit
);

  localparam int LATCH_CYCLES = 2 * HALF_BIT_CYCLES;
  localparam int CNT_MAX = (POLL_CYCLES > LATCH_CYCLES) ? POLL_CYCLES : LATCH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] POLL_TC  = CNT_W'(POLL_CYCLES - 1);
  localparam logic [CNT_W-1:0] LATCH_TC = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_TC  = CNT_W'(HALF_BIT_CYCLES - 1);

  poll_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       cap1_q, cap1_d, cap2_q, cap2_d;
  logic             latch_q, latch_d, pclk_q, pclk_d, commit_q, commit_d;

  // Next-state logic; pad outputs are decoded from the next state so they register cleanly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    cap1_d  = cap1_q;
    cap2_d  = cap2_q;
    case (state_q)
      ST_IDLE: if (cnt_q == POLL_TC) begin
        state_d = ST_LATCH;
        cnt_d   = '0;
      end
      ST_LATCH: if (cnt_q == LATCH_TC) begin
        cap1_d[BTN_A] = ~pad_data1_s;
        cap2_d[BTN_A] = ~pad_data2_s;
        bit_d   = BTN_B;
        state_d = ST_CLK_HI;
        cnt_d   = '0;
      end
      ST_CLK_HI: if (cnt_q == HALF_TC) begin
        state_d = ST_CLK_LO;
        cnt_d   = '0;
      end
      ST_CLK_LO: if (cnt_q == HALF_TC) begin
        cap1_d[bit_q] = ~pad_data1_s;
        cap2_d[bit_q] = ~pad_data2_s;
        cnt_d = '0;
        if (bit_q == BTN_RIGHT) begin
          state_d = ST_COMMIT;
          bit_d   = BTN_A;
        end else begin
          state_d = ST_CLK_HI;
          bit_d   = bit_q + 3'd1;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    latch_d  = (state_d == ST_LATCH);
    pclk_d   = (state_d == ST_CLK_HI);
    commit_d = (state_d == ST_COMMIT);
  end

  // Poller registers; reset aborts any poll in flight without committing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= BTN_A;
      cap1_q   <= '0;
      cap2_q   <= '0;
      latch_q  <= 1'b0;
      pclk_q   <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      cap1_q   <= cap1_d;
      cap2_q   <= cap2_d;
      latch_q  <= latch_d;
      pclk_q   <= pclk_d;
      commit_q <= commit_d;
    end
  end

  assign pad_latch = latch_q;
  assign pad_clk   = pclk_q;
  assign buttons1  = cap1_q;
  assign buttons2  = cap2_q;
  assign commit    = commit_q;

endmodule

// File: rtl/nes_controller_port.sv
// NES $4016/$4017 controller port: pad poller plus CPU-visible strobe/shift registers.
module nes_controller_port
  import nes_ctrl_pkg::*;
#(
  parameter int POLL_CYCLES     = 100000,
  parameter int HALF_BIT_CYCLES = 300
) (
  input  logic                        clk,
  input  logic                        rst_n,
  nes_controller_port_if.slave        cpu,
  output logic                        pad_latch,
  output logic                        pad_clk,
  input  logic                        pad_data1,
  input  logic                        pad_data2
);

  logic       p1_meta_q, p1_meta_d, p1_sync_q, p1_sync_d;
  logic       p2_meta_q, p2_meta_d, p2_sync_q, p2_sync_d;
  logic       strobe_q, strobe_d, rd_act_q, rd_act_d;
  logic [7:0] buttons1_q, buttons1_d, buttons2_q, buttons2_d;
  logic [7:0] sr1_q, sr1_d, sr2_q, sr2_d;
  logic [7:0] poll_btn1, poll_btn2;
  logic       poll_commit;
  logic       rd_act, rd_evt, wr_strobe, sel_bit;

  nes_pad_poller #(
    .POLL_CYCLES    (POLL_CYCLES),
    .HALF_BIT_CYCLES(HALF_BIT_CYCLES)
  ) u_poller (
    .clk        (clk),
    .rst_n      (rst_n),
    .pad_data1_s(p1_sync_q),
    .pad_data2_s(p2_sync_q),
    .pad_latch  (pad_latch),
    .pad_clk    (pad_clk),
    .buttons1   (poll_btn1),
    .buttons2   (poll_btn2),
    .commit     (poll_commit)
  );

  // Bus decode, strobe, commit capture and shift-register next values.
  always_comb begin
    rd_act    = cpu.rd & ~cpu.cs_n;
    rd_evt    = rd_act & ~rd_act_q;
    wr_strobe = cpu.wr & ~cpu.cs_n & ~cpu.addr;
    p1_meta_d = pad_data1;
    p1_sync_d = p1_meta_q;
    p2_meta_d = pad_data2;
    p2_sync_d = p2_meta_q;
    rd_act_d  = rd_act;
    // Only bit 0 of the write data is the strobe; the rest is masked off.
    strobe_d   = wr_strobe ? ((cpu.wr_data & 8'h01) != 8'h00) : strobe_q;
    buttons1_d = poll_commit ? poll_btn1 : buttons1_q;
    buttons2_d = poll_commit ? poll_btn2 : buttons2_q;
    // Reload has priority over a read shift while strobe is held.
    sr1_d = sr1_q;
    sr2_d = sr2_q;
    if (strobe_q) begin
      sr1_d = buttons1_q;
      sr2_d = buttons2_q;
    end else if (rd_evt) begin
      if (cpu.addr) sr2_d = {1'b1, sr2_q[7:1]};
      else          sr1_d = {1'b1, sr1_q[7:1]};
    end
    sel_bit     = cpu.addr ? sr2_q[0] : sr1_q[0];
    cpu.rd_data = rd_act ? (OPEN_BUS | {7'b0, sel_bit}) : 8'h00;
  end

  // CPU-side and synchronizer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p1_meta_q  <= 1'b0;
      p1_sync_q  <= 1'b0;
      p2_meta_q  <= 1'b0;
      p2_sync_q  <= 1'b0;
      strobe_q   <= 1'b0;
      rd_act_q   <= 1'b0;
      buttons1_q <= 8'h00;
      buttons2_q <= 8'h00;
      sr1_q      <= 8'h00;
      sr2_q      <= 8'h00;
    end else begin
      p1_meta_q  <= p1_meta_d;
      p1_sync_q  <= p1_sync_d;
      p2_meta_q  <= p2_meta_d;
      p2_sync_q  <= p2_sync_d;
      strobe_q   <= strobe_d;
      rd_act_q   <= rd_act_d;
      buttons1_q <= buttons1_d;
      buttons2_q <= buttons2_d;
      sr1_q      <= sr1_d;
      sr2_q      <= sr2_d;
    end
  end

endmodule

// File: tb/tb_nes_controller_port.sv
// Directed bench for nes_controller_port with a behavioural pad model.
module tb_nes_controller_port;

  localparam int POLL = 20;
  localparam int HALF = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pad_latch, pad_clk, pad_data1, pad_data2;

  nes_controller_port_if cpu ();

  nes_controller_port #(
    .POLL_CYCLES    (POLL),
    .HALF_BIT_CYCLES(HALF)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu      (cpu),
    .pad_latch(pad_latch),
    .pad_clk  (pad_clk),
    .pad_data1(pad_data1),
    .pad_data2(pad_data2)
  );

  always #5 clk = ~clk;

  // Pad model: 1 = pressed. Pad 1 holds A+Start, pad 2 holds Right.
  logic [7:0] btn1 = 8'h09;
  logic [7:0] btn2 = 8'h80;
  int pidx = 0;

  always @(posedge pad_clk or posedge pad_latch) begin
    if (pad_latch) pidx <= 0;
    else           pidx <= pidx + 1;
  end

  assign pad_data1 = (pidx < 8) ? ~btn1[pidx[2:0]] : 1'b0;
  assign pad_data2 = (pidx < 8) ? ~btn2[pidx[2:0]] : 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic a, input logic [7:0] d);
    cpu.cs_n = 1'b0; cpu.addr = a; cpu.wr = 1'b1; cpu.wr_data = d;
    tick();
    cpu.cs_n = 1'b1; cpu.wr = 1'b0; cpu.wr_data = 8'h00;
  endtask

  task automatic cpu_read(input logic a, input logic [7:0] exp, input string tag);
    cpu.cs_n = 1'b0; cpu.addr = a; cpu.rd = 1'b1;
    #2;
    check(tag, {24'h0, cpu.rd_data}, {24'h0, exp});
    tick();
    cpu.cs_n = 1'b1; cpu.rd = 1'b0;
    tick();
  endtask

  task automatic wait_latch(output int n);
    n = 0;
    while (pad_latch !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n, lw, pulses, falls;
    logic prev;
    logic [7:0] seq9 [9];
    seq9 = '{8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41};

    cpu.cs_n = 1'b1; cpu.addr = 1'b0; cpu.rd = 1'b0; cpu.wr = 1'b0; cpu.wr_data = 8'h00;
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_pad_latch", {31'h0, pad_latch}, 32'h0);
    check("rst_pad_clk",   {31'h0, pad_clk},   32'h0);
    check("idle_rd_data",  {24'h0, cpu.rd_data}, 32'h0);

    // First poll: latch delay, latch width, clock pulse count.
    rst_n = 1'b1;
    wait_latch(n);
    check("first_latch_delay", n, 20);
    lw = 1;
    while (pad_latch === 1'b1 && lw < 50) begin
      tick();
      if (pad_latch === 1'b1) lw++;
    end
    check("latch_width", lw, 4);
    pulses = 0;
    prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (pad_clk === 1'b1 && prev === 1'b0) pulses++;
      prev = pad_clk;
      tick();
    end
    check("pad_clk_pulses", pulses, 7);

    // Committed data is not visible until a strobe reloads the shifters.
    cpu_read(1'b0, 8'h40, "no_vis_before_strobe");

    // Reload 0x09 and shift it all out, then the 1-fill.
    cpu_write(1'b0, 8'h01);
    cpu_write(1'b0, 8'h00);
    for (int i = 0; i < 9; i++) cpu_read(1'b0, seq9[i], $sformatf("seq4016_%0d", i));

    // Held read gives one shift and a steady rd_data; deselected read does nothing.
    cpu_write(1'b0, 8'h01);
    cpu_write(1'b0, 8'h00);
    cpu.cs_n = 1'b1; cpu.rd = 1'b1;
    #2;
    check("deselected_rd_data", {24'h0, cpu.rd_data}, 32'h0);
    tick();
    cpu.rd = 1'b0;
    tick();
    cpu_read(1'b0, 8'h41, "pre_hold_read");
    cpu.cs_n = 1'b0; cpu.addr = 1'b0; cpu.rd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #2;
      check($sformatf("held_rd_%0d", i), {24'h0, cpu.rd_data}, 32'h40);
      tick();
    end
    cpu.cs_n = 1'b1; cpu.rd = 1'b0;
    tick();
    // Write to $4017 must not touch strobe.
    cpu_write(1'b1, 8'h01);
    cpu_read(1'b0, 8'h40, "post_hold_read1");
    cpu_read(1'b0, 8'h41, "post_hold_read2");

    // Strobe held: $4017 reads return bit 0 of buttons2 and never shift.
    cpu_write(1'b0, 8'h01);
    for (int i = 0; i < 3; i++) cpu_read(1'b1, 8'h40, $sformatf("strobe_rd4017_%0d", i));
    cpu_write(1'b0, 8'h00);
    for (int i = 0; i < 7; i++) cpu_read(1'b1, 8'h40, $sformatf("rd4017_%0d", i));
    cpu_read(1'b1, 8'h41, "rd4017_right");
    cpu_read(1'b1, 8'h41, "rd4017_fill");

    // Reset during CLK_LO of bit 3.
    wait_latch(n);
    check("latch_seen_before_reset", {31'h0, pad_latch}, 32'h1);
    falls = 0;
    prev = pad_clk;
    for (int i = 0; i < 60 && falls < 3; i++) begin
      tick();
      if (pad_clk === 1'b0 && prev === 1'b1) falls++;
      prev = pad_clk;
    end
    check("reached_bit3_clk_lo", falls, 3);
    rst_n = 1'b0;
    tick();
    check("midpoll_rst_latch", {31'h0, pad_latch}, 32'h0);
    check("midpoll_rst_clk",   {31'h0, pad_clk},   32'h0);
    tick();
    rst_n = 1'b1;
    cpu_write(1'b0, 8'h01);
    cpu_write(1'b0, 8'h00);
    cpu_read(1'b0, 8'h40, "rst_buttons1_zero");
    cpu_read(1'b1, 8'h40, "rst_buttons2_zero");
    wait_latch(n);
    check("latch_after_reset", n + 6, 20);

    // Next full poll restores the pad data.
    repeat (40) tick();
    cpu_write(1'b0, 8'h01);
    cpu_write(1'b0, 8'h00);
    cpu_read(1'b0, 8'h41, "recovered_btn1_a");
    cpu_read(1'b1, 8'h40, "recovered_btn2_a");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
